// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 instruction codes and register IDs shared by the pipeline stages
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RRSP    = 4'h4;
  localparam logic [3:0] RNONE   = 4'hF;
endpackage

// File: rtl/d_fwd_mux.sv
// d_fwd_mux: picks an operand from execute, memory, writeback or the register file, in that priority
module d_fwd_mux #(
  parameter int W = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic [3:0]   src,
  input  logic [3:0]   e_dst,
  input  logic [W-1:0] e_val,
  input  logic [3:0]   m_dst,
  input  logic [W-1:0] m_val,
  input  logic [3:0]   w_dst,
  input  logic [W-1:0] w_val,
  input  logic [W-1:0] rf_val,
  output logic [W-1:0] val
);
  // a real src never equals RNONE, so a matching dst can never be RNONE either
  assign val = (src == RNONE) ? rf_val :
               (src == e_dst) ? e_val :
               (src == m_dst) ? m_val :
               (src == w_dst) ? w_val : rf_val;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: Y86-64 D pipeline register, register-ID decode, operand forwarding and load-use detection
module decode_stage #(
  parameter int W = 64,
  parameter logic [3:0] RNONE = y86_pkg::RNONE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         f_valid,
  input  logic [3:0]   f_icode,
  input  logic [3:0]   f_ifun,
  input  logic [3:0]   f_rA,
  input  logic [3:0]   f_rB,
  input  logic [W-1:0] f_valC,
  input  logic [W-1:0] f_valP,
  input  logic         d_stall,
  input  logic         d_bubble,
  output logic [3:0]   d_srcA,
  output logic [3:0]   d_srcB,
  input  logic [W-1:0] rf_valA,
  input  logic [W-1:0] rf_valB,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] e_valE,
  input  logic [3:0]   m_dstM,
  input  logic [W-1:0] m_valM,
  input  logic [3:0]   w_dst,
  input  logic [W-1:0] w_val,
  input  logic [3:0]   e_dstM,
  output logic         d_valid,
  output logic [3:0]   d_icode,
  output logic [3:0]   d_ifun,
  output logic [W-1:0] d_valC,
  output logic [W-1:0] d_valA,
  output logic [W-1:0] d_valB,
  output logic [3:0]   d_dstE,
  output logic [3:0]   d_dstM,
  output logic         d_load_use
);
  import y86_pkg::*;
  localparam logic [2*W+16:0] BUBBLE = {1'b0, INOP, 4'h0, RNONE, RNONE, {2*W{1'b0}}};
  logic [2*W+16:0] d;
  logic            valid;
  logic [3:0]      icode, ifun, ra, rb;
  logic [W-1:0]    valc, valp, fwd_a, fwd_b;
  assign {valid, icode, ifun, ra, rb, valc, valp} = d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d <= BUBBLE;
    else if (d_bubble || (!d_stall && !f_valid)) d <= BUBBLE;
    else if (!d_stall) d <= {1'b1, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
  assign d_srcA = !valid ? RNONE :
                  (icode inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) ? ra :
                  (icode inside {IRET, IPOPQ}) ? RRSP : RNONE;
  assign d_srcB = !valid ? RNONE :
                  (icode inside {IRMMOVQ, IMRMOVQ, IOPQ}) ? rb :
                  (icode inside {ICALL, IRET, IPUSHQ, IPOPQ}) ? RRSP : RNONE;
  assign d_dstE = !valid ? RNONE :
                  (icode inside {IRRMOVQ, IIRMOVQ, IOPQ}) ? rb :
                  (icode inside {ICALL, IRET, IPUSHQ, IPOPQ}) ? RRSP : RNONE;
  assign d_dstM = (valid && icode inside {IMRMOVQ, IPOPQ}) ? ra : RNONE;
  assign d_load_use = valid && e_dstM != RNONE && (e_dstM == d_srcA || e_dstM == d_srcB);
  d_fwd_mux #(.W(W), .RNONE(RNONE)) u_fwd_a (
    .src(d_srcA), .e_dst(e_dstE), .e_val(e_valE), .m_dst(m_dstM), .m_val(m_valM),
    .w_dst(w_dst), .w_val(w_val), .rf_val(rf_valA), .val(fwd_a)
  );
  d_fwd_mux #(.W(W), .RNONE(RNONE)) u_fwd_b (
    .src(d_srcB), .e_dst(e_dstE), .e_val(e_valE), .m_dst(m_dstM), .m_val(m_valM),
    .w_dst(w_dst), .w_val(w_val), .rf_val(rf_valB), .val(fwd_b)
  );
  // operands read as zero while reset is held, whatever the register file returns
  assign d_valA = !rst_n ? '0 : (icode == IJXX || icode == ICALL) ? valp : fwd_a;
  assign d_valB = !rst_n ? '0 : fwd_b;
  assign d_valid = valid;
  assign d_icode = icode;
  assign d_ifun = ifun;
  assign d_valC = valc;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a table-driven model
module tb_decode_stage;
  localparam int W = 64;
  localparam logic [3:0] NONE = 4'hF;
  logic clk = 0, rst_n = 1;
  logic f_valid = 0, d_stall = 0, d_bubble = 0;
  logic [3:0] f_icode = 1, f_ifun = 0, f_rA = NONE, f_rB = NONE;
  logic [W-1:0] f_valC = 0, f_valP = 0;
  logic [3:0] e_dstE = NONE, m_dstM = NONE, w_dst = NONE, e_dstM = NONE;
  logic [W-1:0] e_valE = 0, m_valM = 0, w_val = 0;
  logic [W-1:0] rf_valA, rf_valB, d_valC, d_valA, d_valB;
  logic [3:0] d_srcA, d_srcB, d_icode, d_ifun, d_dstE, d_dstM;
  logic d_valid, d_load_use;
  logic [W-1:0] regs [16];
  int n = 0, nerr = 0;
  bit go = 0;

  assign rf_valA = regs[d_srcA];
  assign rf_valB = regs[d_srcB];
  always #5 clk = ~clk;

  decode_stage #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP), .d_stall(d_stall),
    .d_bubble(d_bubble), .d_srcA(d_srcA), .d_srcB(d_srcB), .rf_valA(rf_valA),
    .rf_valB(rf_valB), .e_dstE(e_dstE), .e_valE(e_valE), .m_dstM(m_dstM),
    .m_valM(m_valM), .w_dst(w_dst), .w_val(w_val), .e_dstM(e_dstM), .d_valid(d_valid),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valA(d_valA),
    .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM), .d_load_use(d_load_use)
  );

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // field selectors per icode: 0 none, 1 rA, 2 rB, 3 %rsp
  int SA [16] = '{0,0,1,0,1,0,1,0,0,3,1,3,0,0,0,0};
  int SB [16] = '{0,0,0,0,2,2,2,0,3,3,3,3,0,0,0,0};
  int DE [16] = '{0,0,2,2,0,0,2,0,3,3,3,3,0,0,0,0};
  int DM [16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0};

  logic mv = 0;
  logic [3:0] mic = 1, mif = 0, mra = NONE, mrb = NONE;
  logic [W-1:0] mvc = 0, mvp = 0;

  task automatic mbubble();
    mv = 0; mic = 1; mif = 0; mra = NONE; mrb = NONE; mvc = 0; mvp = 0;
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n || d_bubble || (!d_stall && !f_valid)) mbubble();
    else if (!d_stall) begin
      mv = 1; mic = f_icode; mif = f_ifun; mra = f_rA; mrb = f_rB; mvc = f_valC; mvp = f_valP;
    end

  function automatic logic [3:0] pick(int s, logic [3:0] a, logic [3:0] b);
    return s == 1 ? a : s == 2 ? b : s == 3 ? 4'h4 : NONE;
  endfunction

  function automatic logic [W-1:0] fwd(logic [3:0] s);
    if (s == NONE) return regs[s];
    if (e_dstE == s) return e_valE;
    if (m_dstM == s) return m_valM;
    if (w_dst == s) return w_val;
    return regs[s];
  endfunction

  always @(negedge clk) if (go) begin
    logic [3:0] sa, sb, de, dm;
    logic [W-1:0] va, vb;
    logic lu;
    sa = mv ? pick(SA[mic], mra, mrb) : NONE;
    sb = mv ? pick(SB[mic], mra, mrb) : NONE;
    de = mv ? pick(DE[mic], mra, mrb) : NONE;
    dm = mv ? pick(DM[mic], mra, mrb) : NONE;
    va = !rst_n ? '0 : (mic == 7 || mic == 8) ? mvp : fwd(sa);
    vb = !rst_n ? '0 : fwd(sb);
    lu = mv && e_dstM != NONE && (e_dstM == sa || e_dstM == sb);
    chk("valid", W'(d_valid), W'(mv));
    chk("icode", W'(d_icode), W'(mic));
    chk("ifun", W'(d_ifun), W'(mif));
    chk("valC", d_valC, mvc);
    chk("srcA", W'(d_srcA), W'(sa));
    chk("srcB", W'(d_srcB), W'(sb));
    chk("dstE", W'(d_dstE), W'(de));
    chk("dstM", W'(d_dstM), W'(dm));
    chk("valA", d_valA, va);
    chk("valB", d_valB, vb);
    chk("load_use", W'(d_load_use), W'(lu));
  end

  task automatic ld(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb, logic [W-1:0] vp);
    f_valid = 1; f_icode = ic; f_ifun = 0; f_rA = ra; f_rB = rb; f_valC = 64'h1234; f_valP = vp;
    d_stall = 0; d_bubble = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] rid();
    int v = $urandom_range(0, 6);
    return v == 6 ? NONE : 4'(v);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = {$urandom, $urandom};
    regs[15] = 64'hDEAD_BEEF;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", W'(d_valid), 0);
    chk("rst_srcA", W'(d_srcA), W'(NONE));
    chk("rst_valA", d_valA, 0);
    chk("rst_load_use", W'(d_load_use), 0);
    go = 1;
    @(posedge clk); #1 rst_n = 1;
    regs[1] = 5; regs[2] = 7;
    ld(6, 1, 2, 0);
    chk("opq_valA", d_valA, 5);
    chk("opq_valB", d_valB, 7);
    chk("opq_dstE", W'(d_dstE), 2);
    chk("opq_dstM", W'(d_dstM), W'(NONE));
    ld(6, 3, 2, 0);
    e_dstE = 3; e_valE = 64'hAA; m_dstM = 3; m_valM = 64'hBB;
    #1 chk("fwd_e", d_valA, 64'hAA);
    e_dstE = NONE;
    #1 chk("fwd_m", d_valA, 64'hBB);
    m_dstM = NONE;
    ld(6, 1, 2, 0);
    e_dstM = 1;
    #1 chk("load_use", W'(d_load_use), 1);
    d_stall = 1; f_icode = 3; f_rA = 5;
    @(posedge clk); #1;
    chk("stall_icode", W'(d_icode), 6);
    chk("stall_srcA", W'(d_srcA), 1);
    d_stall = 0; e_dstM = NONE;
    ld(8, NONE, NONE, 64'h40);
    chk("call_valA", d_valA, 64'h40);
    chk("call_srcB", W'(d_srcB), 4);
    chk("call_dstE", W'(d_dstE), 4);
    ld(4'hA, NONE, NONE, 0);
    chk("push_srcA", W'(d_srcA), W'(NONE));
    f_icode = 6; d_stall = 1; d_bubble = 1;
    @(posedge clk); #1;
    chk("sb_valid", W'(d_valid), 0);
    chk("sb_icode", W'(d_icode), 1);
    ld(4'hC, 1, 2, 0);
    chk("bad_valid", W'(d_valid), 1);
    chk("bad_srcA", W'(d_srcA), W'(NONE));
    chk("bad_dstE", W'(d_dstE), W'(NONE));
    ld(6, 1, 2, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", W'(d_valid), 0);
    chk("arst_valA", d_valA, 0);
    chk("arst_srcB", W'(d_srcB), W'(NONE));
    @(posedge clk); #1 rst_n = 1;
    chk("rel_valid", W'(d_valid), 0);
    @(posedge clk); #1;
    chk("rel_load", W'(d_valid), 1);
    chk("rel_icode", W'(d_icode), 6);
    repeat (3000) begin
      rst_n = $urandom_range(0, 49) != 0;
      f_valid = $urandom_range(0, 7) != 0;
      f_icode = 4'($urandom_range(0, 15));
      f_ifun = 4'($urandom_range(0, 15));
      f_rA = rid(); f_rB = rid();
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      d_stall = $urandom_range(0, 4) == 0;
      d_bubble = $urandom_range(0, 6) == 0;
      e_dstE = rid(); m_dstM = rid(); w_dst = rid(); e_dstM = rid();
      e_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom}; w_val = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) regs[$urandom_range(0, 15)] = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    go = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n, nerr);
    $finish;
  end
endmodule
